// File: rtl/bundle_ctrl.sv
// bundle_ctrl: sequencing controller for a majority-vote (bundling) unit.
//
// Hypervector words arrive on a valid/ready stream and are fed straight
// into an external bank of D up/down lane counters: a 0 bit counts up and a
// 1 bit counts down. The controller does not hold the counters. It drives
// cnt_clr, cnt_en and cnt_bits, and it reads back the lane sign bits.
// When the last word of a bundle arrives, the result is produced as follows:
//   - If the bundle has an even number of words, one extra tie-break word is
//     injected so that no lane can end at zero.
//   - One settle cycle follows, and the sign bits are latched into m_data.
//   - The result is offered on m_valid/m_ready.
//   - After the handshake, one cycle clears the counter bank.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   s_valid/s_data/s_last     input word stream; s_ready is the accept qualifier
//   tie_pattern               static tie-break word used for even-sized bundles
//   cnt_clr/cnt_en/cnt_bits   control of the external lane counter bank
//   sign_bits                 per-lane counter MSB (1 = majority of ones)
//   m_valid/m_data/m_ready    bundled result stream
//   item_cnt                  number of words accepted in the current bundle
//   busy                      high whenever the FSM is not in IDLE
module bundle_ctrl #(
    parameter int D  = 32,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    input  logic [D-1:0]  s_data,
    input  logic          s_last,
    output logic          s_ready,
    input  logic [D-1:0]  tie_pattern,
    output logic          cnt_clr,
    output logic          cnt_en,
    output logic [D-1:0]  cnt_bits,
    input  logic [D-1:0]  sign_bits,
    output logic          m_valid,
    output logic [D-1:0]  m_data,
    input  logic          m_ready,
    output logic [CW-1:0] item_cnt,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        TIEBRK,
        SETTLE,
        OUT,
        CLEAR
    } state_t;

    // This is the count that the current accept completes to 2^CW-1. A
    // bundle is forced to end here so that item_cnt can never wrap.
    localparam logic [CW-1:0] FORCE_LAST = {{(CW-1){1'b1}}, 1'b0};

    state_t        state_reg, state_next;
    logic [CW-1:0] item_cnt_reg, item_cnt_next;
    logic [D-1:0]  m_data_reg, m_data_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            item_cnt_reg <= '0;
            m_data_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            item_cnt_reg <= item_cnt_next;
            m_data_reg   <= m_data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        item_cnt_next = item_cnt_reg;
        m_data_next   = m_data_reg;
        s_ready       = 1'b0;
        cnt_en        = 1'b0;
        cnt_clr       = 1'b0;
        cnt_bits      = '0;
        m_valid       = 1'b0;

        if (rst) begin
            // The counter bank has no reset of its own, so it is cleared
            // for as long as reset is held.
            cnt_clr       = 1'b1;
            state_next    = IDLE;
            item_cnt_next = '0;
            m_data_next   = '0;
        end else begin
            case (state_reg)
                IDLE, ACCUM: begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        // The word goes to the counters in the same cycle
                        // it is accepted.
                        cnt_en        = 1'b1;
                        cnt_bits      = s_data;
                        item_cnt_next = item_cnt_reg + 1'b1;
                        if (s_last || item_cnt_reg == FORCE_LAST) begin
                            // The new count is item_cnt_reg+1. That count
                            // is even exactly when item_cnt_reg is odd, and
                            // an even count needs a tie-break word.
                            state_next = item_cnt_reg[0] ? TIEBRK : SETTLE;
                        end else begin
                            state_next = ACCUM;
                        end
                    end
                end
                TIEBRK: begin
                    cnt_en     = 1'b1;
                    cnt_bits   = tie_pattern;
                    state_next = SETTLE;
                end
                SETTLE: begin
                    // The counters now hold the final word, so their sign
                    // bits are the majority result.
                    m_data_next = sign_bits;
                    state_next  = OUT;
                end
                OUT: begin
                    m_valid = 1'b1;
                    if (m_ready) begin
                        state_next = CLEAR;
                    end
                end
                CLEAR: begin
                    cnt_clr       = 1'b1;
                    item_cnt_next = '0;
                    state_next    = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign m_data   = m_data_reg;
    assign item_cnt = item_cnt_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_bundle_ctrl.sv
// tb_bundle_ctrl: self-checking bench for bundle_ctrl (D=4, CW=3).
// The bench provides a behavioural lane counter bank for sign_bits. It also
// provides a majority-vote reference that works on whole bundles of words.
module tb_bundle_ctrl;
    localparam int D    = 4;
    localparam int CW   = 3;
    localparam int MAXW = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic [D-1:0]  s_data;
    logic          s_last;
    logic          s_ready;
    logic [D-1:0]  tie_pattern;
    logic          cnt_clr;
    logic          cnt_en;
    logic [D-1:0]  cnt_bits;
    logic [D-1:0]  sign_bits;
    logic          m_valid;
    logic [D-1:0]  m_data;
    logic          m_ready;
    logic [CW-1:0] item_cnt;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;

    always #5 clk = ~clk;

    bundle_ctrl #(.D(D), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .tie_pattern(tie_pattern),
        .cnt_clr(cnt_clr), .cnt_en(cnt_en), .cnt_bits(cnt_bits),
        .sign_bits(sign_bits),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .item_cnt(item_cnt), .busy(busy)
    );

    // Lane counter bank: a 0 bit counts up, a 1 bit counts down, and clear
    // wins over enable.
    int lane_cnt [D];
    initial for (int i = 0; i < D; i++) lane_cnt[i] = 0;
    always @(posedge clk) begin
        for (int i = 0; i < D; i++) begin
            if (cnt_clr)     lane_cnt[i] <= 0;
            else if (cnt_en) lane_cnt[i] <= lane_cnt[i] + (cnt_bits[i] ? -1 : 1);
        end
    end
    always_comb begin
        sign_bits = '0;
        for (int i = 0; i < D; i++) sign_bits[i] = (lane_cnt[i] < 0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    // Reference model: a bundle's result is the per-lane majority of its
    // words. An even-sized bundle also counts tie_pattern as one extra vote.
    logic [D-1:0] cur[$];
    logic [D-1:0] exp_q[$];

    function automatic logic [D-1:0] majority();
        logic [D-1:0] res;
        res = '0;
        for (int i = 0; i < D; i++) begin
            int ones;
            int n;
            ones = 0;
            n = cur.size();
            foreach (cur[k]) ones += int'(cur[k][i]);
            if (n % 2 == 0) begin
                ones += int'(tie_pattern[i]);
                n++;
            end
            res[i] = (2 * ones > n);
        end
        return res;
    endfunction

    // Monitor: samples mid-cycle, after the main process has driven inputs.
    always @(negedge clk) begin
        #2;
        chk("excl", {31'd0, cnt_en & cnt_clr}, 32'd0);
        if (rst) begin
            cur.delete();
            exp_q.delete();
        end else begin
            if (s_valid && s_ready) begin
                chk("acc_en", {31'd0, cnt_en}, 32'd1);
                chk("acc_bits", {28'd0, cnt_bits}, {28'd0, s_data});
                cur.push_back(s_data);
                if (s_last || cur.size() == MAXW) begin
                    exp_q.push_back(majority());
                    cur.delete();
                end
            end else if (!cnt_en) begin
                chk("bits_zero", {28'd0, cnt_bits}, 32'd0);
            end
            if (m_valid && m_ready) begin
                chk("out_pending", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    $display("bundle %0d: m_data=%b items=%0d", n_out, m_data, item_cnt);
                    chk("m_data", {28'd0, m_data}, {28'd0, exp_q.pop_front()});
                    n_out++;
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [D-1:0] d, input logic l,
                         input logic mr, input logic r);
        @(negedge clk);
        rst = r; s_valid = v; s_data = d; s_last = l; m_ready = mr;
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        m_ready = 1'b1; tie_pattern = 4'b1010;

        // Reset state
        drive(0, 4'h0, 0, 1, 1);
        drive(0, 4'h0, 0, 1, 1);
        chk("rst_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_clr", {31'd0, cnt_clr}, 32'd1);
        chk("rst_en", {31'd0, cnt_en}, 32'd0);
        chk("rst_mvalid", {31'd0, m_valid}, 32'd0);
        chk("rst_mdata", {28'd0, m_data}, 32'd0);
        chk("rst_item", {29'd0, item_cnt}, 32'd0);

        // Odd bundle 0011, 0101, 0110 gives 0111 two cycles after the final word.
        drive(1, 4'b0011, 0, 1, 0);
        chk("t1_ready", {31'd0, s_ready}, 32'd1);
        chk("t1_busy0", {31'd0, busy}, 32'd0);
        chk("t1_bits", {28'd0, cnt_bits}, 32'b0011);
        drive(1, 4'b0101, 0, 1, 0);
        chk("t1_item1", {29'd0, item_cnt}, 32'd1);
        drive(1, 4'b0110, 1, 1, 0);
        chk("t1_item2", {29'd0, item_cnt}, 32'd2);
        drive(0, 4'h0, 0, 1, 0);
        chk("t1_settle_mv", {31'd0, m_valid}, 32'd0);
        chk("t1_settle_rdy", {31'd0, s_ready}, 32'd0);
        chk("t1_settle_en", {31'd0, cnt_en}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        drive(0, 4'h0, 0, 1, 0);
        chk("t1_mvalid", {31'd0, m_valid}, 32'd1);
        chk("t1_mdata", {28'd0, m_data}, 32'b0111);
        chk("t1_item3", {29'd0, item_cnt}, 32'd3);
        drive(0, 4'h0, 0, 1, 0);
        chk("t1_clear", {31'd0, cnt_clr}, 32'd1);
        chk("t1_clear_mv", {31'd0, m_valid}, 32'd0);
        chk("t1_clear_rdy", {31'd0, s_ready}, 32'd0);
        drive(0, 4'h0, 0, 1, 0);
        chk("t1_idle_rdy", {31'd0, s_ready}, 32'd1);
        chk("t1_idle_item", {29'd0, item_cnt}, 32'd0);

        // Even bundle with a tie-break word, then backpressure in OUT.
        drive(1, 4'b1100, 0, 1, 0);
        drive(1, 4'b0000, 1, 1, 0);
        drive(0, 4'h0, 0, 1, 0);
        chk("t2_tie_en", {31'd0, cnt_en}, 32'd1);
        chk("t2_tie_bits", {28'd0, cnt_bits}, 32'b1010);
        chk("t2_tie_item", {29'd0, item_cnt}, 32'd2);
        chk("t2_tie_rdy", {31'd0, s_ready}, 32'd0);
        drive(0, 4'h0, 0, 1, 0);
        chk("t2_settle_mv", {31'd0, m_valid}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 4'h0, 0, 0, 0);
            chk("t3_hold_mv", {31'd0, m_valid}, 32'd1);
            chk("t3_hold_md", {28'd0, m_data}, 32'b1000);
            chk("t3_hold_rdy", {31'd0, s_ready}, 32'd0);
            chk("t3_hold_clr", {31'd0, cnt_clr}, 32'd0);
        end
        drive(0, 4'h0, 0, 1, 0);
        chk("t3_hs_mv", {31'd0, m_valid}, 32'd1);
        drive(0, 4'h0, 0, 1, 0);
        chk("t3_clear", {31'd0, cnt_clr}, 32'd1);
        drive(0, 4'h0, 0, 1, 0);
        chk("t3_idle_rdy", {31'd0, s_ready}, 32'd1);

        // Seven words without s_last: the seventh is a forced, odd final word.
        for (int i = 0; i < 7; i++) begin
            drive(1, (i % 2 == 0) ? 4'b1010 : 4'b0101, 0, 1, 0);
            chk("t4_item", {29'd0, item_cnt}, i);
            chk("t4_rdy", {31'd0, s_ready}, 32'd1);
        end
        drive(1, 4'b1111, 0, 1, 0);
        chk("t4_settle_rdy", {31'd0, s_ready}, 32'd0);
        chk("t4_settle_en", {31'd0, cnt_en}, 32'd0);
        chk("t4_settle_mv", {31'd0, m_valid}, 32'd0);
        drive(0, 4'h0, 0, 1, 0);
        chk("t4_mvalid", {31'd0, m_valid}, 32'd1);
        chk("t4_mdata", {28'd0, m_data}, 32'b1010);
        chk("t4_item7", {29'd0, item_cnt}, 32'd7);
        drive(0, 4'h0, 0, 1, 0);
        drive(0, 4'h0, 0, 1, 0);
        chk("t4_idle_rdy", {31'd0, s_ready}, 32'd1);

        // A reset pulse in the middle of a bundle discards it.
        drive(1, 4'b1111, 0, 1, 0);
        drive(1, 4'b1111, 0, 1, 0);
        drive(0, 4'h0, 0, 1, 1);
        chk("t5_rst_clr", {31'd0, cnt_clr}, 32'd1);
        chk("t5_rst_rdy", {31'd0, s_ready}, 32'd0);
        drive(1, 4'b1001, 1, 1, 0);
        chk("t5_rdy", {31'd0, s_ready}, 32'd1);
        chk("t5_item0", {29'd0, item_cnt}, 32'd0);
        drive(0, 4'h0, 0, 1, 0);
        drive(0, 4'h0, 0, 1, 0);
        chk("t5_mvalid", {31'd0, m_valid}, 32'd1);
        chk("t5_mdata", {28'd0, m_data}, 32'b1001);
        drive(0, 4'h0, 0, 1, 0);
        drive(0, 4'h0, 0, 1, 0);

        // Random traffic with input gaps and output backpressure.
        tie_pattern = 4'($urandom);
        for (int c = 0; c < 1500; c++) begin
            drive(($urandom % 4) != 0, 4'($urandom), ($urandom % 4) == 0,
                  ($urandom % 3) != 0, 0);
        end
        for (int c = 0; c < 20; c++) drive(0, 4'h0, 0, 1, 0);
        chk("drain", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
